// File: rtl/interrupt_arbiter.sv
// Shares the kcpsm6 interrupt among NUM_SRC latched requesters and serves the granted byte / source ID on the input port.
// Define ROUND_ROBIN_EN for round-robin arbitration; the default build uses fixed priority (source 0 highest).
module interrupt_arbiter #(
  parameter int unsigned NUM_SRC     = 4,
  parameter int unsigned ACK_TIMEOUT = 255,
  parameter logic [7:0]  DATA_PORT   = 8'h00,
  parameter logic [7:0]  SRC_PORT    = 8'h03,
  parameter logic [7:0]  CLR_PORT    = 8'h04
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_SRC-1:0]     req,
  input  logic [8*NUM_SRC-1:0]   src_data,
  output logic                   interrupt,
  input  logic                   interrupt_ack,
  input  logic [7:0]             port_id,
  input  logic                   read_strobe,
  input  logic                   write_strobe,
  output logic [7:0]             cpu_in,
  output logic [1:0]             grant_id,
  output logic                   busy,
  output logic [NUM_SRC-1:0]     overrun,
  output logic                   timeout_err
);

  typedef enum logic [1:0] {S_IDLE, S_ASSERT, S_SERVICE} state_t;

  state_t               state_q, state_d;
  logic [NUM_SRC-1:0]   req_dly_q;
  logic [NUM_SRC-1:0]   pending_q, pending_d;
  logic [NUM_SRC-1:0]   overrun_q, overrun_d;
  logic [7:0]           hold_q [NUM_SRC];
  logic [7:0]           hold_d [NUM_SRC];
  logic [1:0]           grant_id_q, grant_id_d;
  logic [7:0]           counter_q, counter_d;
  logic [7:0]           cpu_in_q, cpu_in_d;
  logic                 timeout_err_q, timeout_err_d;

  logic [NUM_SRC-1:0]   rise, clr_pend;
  logic [2*NUM_SRC-1:0] rot;
  logic [1:0]           start, winner;
  logic                 found, timeout_hit, clr_err;
  logic [7:0]           sel_data;
`ifdef ROUND_ROBIN_EN
  logic [1:0]           last_q, last_d;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      req_dly_q     <= '0;
      pending_q     <= '0;
      overrun_q     <= '0;
      hold_q        <= '{default: '0};
      grant_id_q    <= '0;
      counter_q     <= '0;
      cpu_in_q      <= '0;
      timeout_err_q <= 1'b0;
`ifdef ROUND_ROBIN_EN
      last_q        <= 2'(NUM_SRC - 1);
`endif
    end else begin
      state_q       <= state_d;
      req_dly_q     <= req;
      pending_q     <= pending_d;
      overrun_q     <= overrun_d;
      hold_q        <= hold_d;
      grant_id_q    <= grant_id_d;
      counter_q     <= counter_d;
      cpu_in_q      <= cpu_in_d;
      timeout_err_q <= timeout_err_d;
`ifdef ROUND_ROBIN_EN
      last_q        <= last_d;
`endif
    end
  end

  // Rotate the pending vector so the search always runs from bit 0 upward.
  always_comb begin
`ifdef ROUND_ROBIN_EN
    start = 2'((32'(last_q) + 1) % NUM_SRC);
`else
    start = '0;
`endif
    rot    = {pending_q, pending_q} >> start;
    winner = '0;
    found  = 1'b0;
    for (int unsigned off = 0; off < NUM_SRC; off++) begin
      if (!found && rot[off]) begin
        winner = 2'((32'(start) + off) % NUM_SRC);
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_id_d  = grant_id_q;
    counter_d   = counter_q;
    clr_pend    = '0;
    timeout_hit = 1'b0;
`ifdef ROUND_ROBIN_EN
    last_d      = last_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (|pending_q) begin
          state_d    = S_ASSERT;
          grant_id_d = winner;
          counter_d  = '0;
        end
      end
      S_ASSERT: begin
        if (interrupt_ack) begin
          state_d   = S_SERVICE;
          counter_d = '0;
          for (int unsigned i = 0; i < NUM_SRC; i++)
            if (grant_id_q == 2'(i)) clr_pend[i] = 1'b1;
`ifdef ROUND_ROBIN_EN
          last_d = grant_id_q;
`endif
        end else if (counter_q == 8'(ACK_TIMEOUT - 1)) begin
          state_d     = S_IDLE;
          timeout_hit = 1'b1;
        end else begin
          counter_d = counter_q + 8'd1;
        end
      end
      S_SERVICE: begin
        if (read_strobe && (port_id == DATA_PORT)) begin
          state_d = S_IDLE;
        end else if (counter_q == 8'(ACK_TIMEOUT - 1)) begin
          state_d     = S_IDLE;
          timeout_hit = 1'b1;
        end else begin
          counter_d = counter_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A new rising edge beats a same-cycle clear, both for pending and for the error flags.
  always_comb begin
    rise          = req & ~req_dly_q;
    clr_err       = write_strobe && (port_id == CLR_PORT);
    pending_d     = (pending_q & ~clr_pend) | rise;
    overrun_d     = (clr_err ? '0 : overrun_q) | (rise & pending_q & ~clr_pend);
    timeout_err_d = (timeout_err_q & ~clr_err) | timeout_hit;
    hold_d        = hold_q;
    for (int unsigned i = 0; i < NUM_SRC; i++)
      if (rise[i]) hold_d[i] = src_data[8*i +: 8];
  end

  always_comb begin
    sel_data = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++)
      if (grant_id_q == 2'(i)) sel_data = hold_q[i];
    if (port_id == DATA_PORT)     cpu_in_d = sel_data;
    else if (port_id == SRC_PORT) cpu_in_d = {6'b0, grant_id_q};
    else                          cpu_in_d = 8'h00;
  end

  always_comb begin
    interrupt = (state_q == S_ASSERT);
    busy      = (state_q != S_IDLE);
  end

  assign cpu_in      = cpu_in_q;
  assign grant_id    = grant_id_q;
  assign overrun     = overrun_q;
  assign timeout_err = timeout_err_q;

endmodule
